// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin / fixed-priority arbiter feeding one registered output stage
module rr_arb_mux #(
    parameter int WIDTH  = 64,
    parameter int NUM_CH = 4,
    parameter int MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*WIDTH-1:0]        in_data,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_data;
    logic              found;
    logic              free;
    logic              accept;
    int                idx;

    // Search starts at ptr in round-robin mode and at 0 in fixed-priority mode.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel_data  = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (MODE == 1) ? k : (int'(ptr_q) + k) % NUM_CH;
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                sel_data   = in_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Reset gates in_ready directly so nothing is accepted while rst is held.
    assign free     = ~out_valid_q | out_ready;
    assign accept   = found & free & ~rst;
    assign in_ready = grant & {NUM_CH{free & ~rst}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = grant_idx;
            if (MODE == 0) begin
                ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard bench for rr_arb_mux (RR x4, fixed-priority x4, RR x3)
module tb_rr_arb_mux;

    typedef struct {
        logic [63:0] data;
        int          ch;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0][3:0]   iv;
    logic [2:0][255:0] id;
    logic [2:0]        ordy;

    logic [3:0]  ir_0, ir_1;
    logic [2:0]  ir_2;
    logic [63:0] od_0, od_1, od_2;
    logic [1:0]  oc_0, oc_1, oc_2;
    logic        ov_0, ov_1, ov_2;

    logic [2:0][3:0]  ir;
    logic [2:0][63:0] od;
    logic [2:0][1:0]  oc;
    logic [2:0]       ov;

    assign ir = {{1'b0, ir_2}, ir_1, ir_0};
    assign od = {od_2, od_1, od_0};
    assign oc = {oc_2, oc_1, oc_0};
    assign ov = {ov_2, ov_1, ov_0};

    rr_arb_mux #(.WIDTH(64), .NUM_CH(4), .MODE(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir_0),
        .out_data(od_0), .out_ch(oc_0), .out_valid(ov_0), .out_ready(ordy[0]));

    rr_arb_mux #(.WIDTH(64), .NUM_CH(4), .MODE(1)) u_fp4 (
        .clk(clk), .rst(rst), .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir_1),
        .out_data(od_1), .out_ch(oc_1), .out_valid(ov_1), .out_ready(ordy[1]));

    rr_arb_mux #(.WIDTH(64), .NUM_CH(3), .MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_data(id[2][191:0]), .in_valid(iv[2][2:0]), .in_ready(ir_2),
        .out_data(od_2), .out_ch(oc_2), .out_valid(ov_2), .out_ready(ordy[2]));

    int checks = 0;
    int errors = 0;

    beat_t q0[$], q1[$], q2[$];
    int         m_next[3];
    bit         m_ov[3];
    bit         pend[3];
    logic [3:0] exp_ir[3];
    bit         started = 1'b0;

    localparam int RST_AT = 60;
    localparam int NCYC   = 600;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_q(input int d, input beat_t b);
        case (d)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t pop_q(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int d = 0; d < 3; d++) begin
            m_next[d] = 0;
            m_ov[d]   = 1'b0;
            pend[d]   = 1'b0;
            exp_ir[d] = 4'h0;
        end
    endfunction

    // Spec-level model: the winner is the first valid channel found scanning
    // from the slot after the last winner (or from 0 for fixed priority).
    function automatic void model_step();
        for (int d = 0; d < 3; d++) begin
            int  n    = (d == 2) ? 3 : 4;
            bit  fp   = (d == 1);
            bit  free = !m_ov[d] || ordy[d];
            int  g    = -1;
            for (int k = 0; k < n; k++) begin
                int c = fp ? k : (m_next[d] + k) % n;
                if (g < 0 && iv[d][c]) g = c;
            end
            pend[d]   = 1'b0;
            exp_ir[d] = 4'h0;
            if (free && g >= 0) begin
                beat_t b;
                b.data = id[d][g*64 +: 64];
                b.ch   = g;
                push_q(d, b);
                exp_ir[d] = 4'(1 << g);
                pend[d]   = 1'b1;
                m_ov[d]   = 1'b1;
                if (!fp) m_next[d] = (g + 1) % n;
            end else if (ordy[d]) begin
                m_ov[d] = 1'b0;
            end
        end
    endfunction

    task automatic drive(input int cyc);
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (cyc < 20) id[d][i*64 +: 64] = 64'hA0 + 64'(i);
                else          id[d][i*64 +: 64] = {$urandom, $urandom};
            end
            if (cyc < 20) begin
                iv[d]   = 4'hF;
                ordy[d] = 1'b1;
            end else if (cyc < 40) begin
                iv[d]   = {2'b00, 1'($urandom), 1'b0};
                ordy[d] = 1'b1;
            end else if (cyc < 56) begin
                iv[d]   = 4'($urandom);
                ordy[d] = 1'($urandom_range(0, 1));
            end else if (cyc < RST_AT) begin
                iv[d]   = 4'hF;
                ordy[d] = 1'b0;
            end else begin
                iv[d]   = 4'($urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
            end
        end
        iv[2][3] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            for (int d = 0; d < 3; d++) begin
                beat_t b;
                chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(exp_ir[d]));
                chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'((q_size(d) - int'(pend[d])) > 0));
                if (ov[d] && ordy[d]) begin
                    if (q_size(d) == 0) begin
                        chk($sformatf("unexpected_beat[%0d]", d), 64'd1, 64'd0);
                    end else begin
                        b = pop_q(d);
                        chk($sformatf("out_data[%0d]", d), od[d], b.data);
                        chk($sformatf("out_ch[%0d]", d), 64'(oc[d]), 64'(b.ch));
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        iv   = '1;
        id   = '1;
        ordy = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
            chk($sformatf("rst_out_data[%0d]", d), od[d], 64'd0);
            chk($sformatf("rst_out_ch[%0d]", d), 64'(oc[d]), 64'd0);
            chk($sformatf("rst_in_ready[%0d]", d), 64'(ir[d]), 64'd0);
        end
        iv = '0;
        repeat (2) @(posedge clk);
        #3;
        rst     = 1'b0;
        started = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == RST_AT) begin
                for (int d = 0; d < 3; d++)
                    chk($sformatf("stall_valid[%0d]", d), 64'(ov[d]), 64'(m_ov[d]));
                #3;
                rst = 1'b1;
                #1;
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("async_rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
                    chk($sformatf("async_rst_out_data[%0d]", d), od[d], 64'd0);
                    chk($sformatf("async_rst_out_ch[%0d]", d), 64'(oc[d]), 64'd0);
                    chk($sformatf("async_rst_in_ready[%0d]", d), 64'(ir[d]), 64'd0);
                end
                repeat (2) @(posedge clk);
                #3;
                model_reset();
                iv       = '1;
                iv[2][3] = 1'b0;
                ordy     = '1;
                rst      = 1'b0;
                model_step();
            end else begin
                drive(cyc);
                model_step();
            end
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
